mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage controller sitting between the EX/MEM pipeline register and the data-memory bus. It decodes load/store instructions leaving EX/MEM, sequences a valid/ready request and response transaction on the data bus, and generates byte strobes, store-data lane replication and load alignment/extension. It stalls the upstream pipeline while a transaction is outstanding and presents the final writeback triple (data, rd, enable) to the MEM/WB register.

## Interface
- DATA_WIDTH, 64, datapath and bus data width; fixed at 64 (8 byte lanes)
- ADDR_WIDTH, 64, address width
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, synchronous, active-low
- OpCodeIn  in  7  opcode from EX/MEM
- Funct3In  in  3  funct3 from EX/MEM
- AddrIn  in  64  effective address (EX/MEM RdWriteData)
- StoreDataIn  in  64  store data (EX/MEM Rs2ReadData)
- RdAddrIn  in  5  destination register
- RdWriteEnableIn  in  1  destination write enable
- RdWriteDataIn  in  64  ALU result for non-memory instructions
- MemReqValid  out  1  request valid
- MemReqReady  in  1  bus accepts request
- MemReqAddr  out  64  request address, AddrIn with [2:0] cleared
- MemReqWrite  out  1  1 = store, 0 = load
- MemReqWdata  out  64  lane-replicated store data
- MemReqWstrb  out  8  byte strobes (0 for loads)
- MemRespValid  in  1  load response valid
- MemRespRdata  in  64  load response data
- StallOut  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- RdWriteDataOut  out  64  writeback data to MEM/WB
- RdAddrOut  out  5  writeback rd
- RdWriteEnableOut  out  1  writeback enable
- MemFault  out  1  one-cycle misalignment/illegal-width pulse

## Operation
- Load = opcode 7'b0000011; store = 7'b0100011; everything else is non-memory.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, non-memory: combinational pass-through of RdWriteDataIn/RdAddrIn/RdWriteEnableIn; StallOut=0.
- IDLE, legal memory op: StallOut=1, RdWriteEnableOut=0; capture addr, funct3, rd, write flag, wdata, wstrb; go to REQ.
- Legality: half needs addr[0]=0, word addr[1:0]=0, double addr[2:0]=0; load funct3 3'b111 and store funct3 >= 3'b100 are illegal. Illegal -> MemFault=1 that cycle, no request, StallOut=0, RdWriteEnableOut=0, stay IDLE.
- Store lanes, off=addr[2:0]: SB strobe 8'h01<<off, byte replicated x8; SH 8'h03<<off, half x4; SW 8'h0F<<off, word x2; SD 8'hFF, data as-is.
- REQ: MemReqValid=1 with payload held stable until MemReqReady. On handshake: store -> DONE, load -> WAIT.
- WAIT: on MemRespValid, shift MemRespRdata right by off*8, then LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD unchanged; latch result; go to DONE.
- DONE: StallOut=0; load -> RdWriteDataOut=latched data, RdAddrOut=captured rd, RdWriteEnableOut=captured enable; store -> RdWriteEnableOut=0. Always return to IDLE.
- MemRespValid outside WAIT is ignored.

## Timing
- Reset (Rst=0 at edge): state IDLE; MemReqValid, MemReqWrite, MemReqWstrb, MemReqAddr, MemReqWdata, and the latched load data all 0. While Rst=0, StallOut=0, RdWriteEnableOut=0, MemFault=0.
- Reset mid-transaction, in REQ or WAIT, abandons the access: next cycle is IDLE, MemReqValid=0, and a late response is dropped.
- MemReqValid is registered: it rises the cycle after IDLE detection and drops the cycle after the handshake.
- Load, zero-wait bus (ready in first REQ cycle, response the following cycle): IDLE(c0), REQ(c1), WAIT(c2), DONE(c3). StallOut is high c0-c2 and the writeback is valid in c3.
- Store, zero-wait bus: IDLE(c0), REQ(c1), DONE(c2). StallOut is high c0-c1.
- Each cycle without MemReqReady in REQ, or without MemRespValid in WAIT, adds exactly one stall cycle.
- The pipeline advances at the end of DONE, so IDLE sees a new instruction on the next cycle. Back-to-back memory ops incur no extra bubble.

## Test plan
- ALU op (opcode 0110011, RdWriteDataIn=0x1234, rd=5, we=1) -> same-cycle pass-through, StallOut=0, MemReqValid never high.
- LB at addr 0x1003, MemRespRdata=0x0000_0000_8000_0000, zero-wait -> request addr 0x1000, wstrb 0, DONE writes 0xFFFF_FFFF_FFFF_FF80 to rd; StallOut high exactly 3 cycles.
- SH at addr 0x2006, data 0xABCD, MemReqReady low 2 cycles -> payload stable, wstrb 8'hC0, wdata 0xABCD_ABCD_ABCD_ABCD, StallOut high 4 cycles, RdWriteEnableOut=0.
- LW at addr 0x3002 -> MemFault pulse for 1 cycle, no request, StallOut=0, no writeback.
- LWU at 0x4004, rdata 0xFFFF_FFFF_0000_0001, response delayed 3 cycles -> writeback 0x0000_0000_FFFF_FFFF after 6 stall cycles; a stray MemRespValid in IDLE is ignored.
- Rst=0 asserted in WAIT with a response pending -> IDLE next cycle, all outputs at reset values, no writeback for the abandoned load.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage controller between the EX/MEM register and the data bus.
//   Decodes loads/stores, runs one valid/ready request (plus a response for
//   loads), builds byte strobes and lane-replicated store data, and aligns
//   and extends load data. The upstream pipeline is stalled while a
//   transaction is outstanding. The writeback triple goes to MEM/WB.
//
// Ports
//   Clk, Rst            clock, synchronous active-low reset
//   OpCodeIn/Funct3In   instruction decode fields from EX/MEM
//   AddrIn              effective address
//   StoreDataIn         store data (rs2)
//   RdAddrIn/RdWriteEnableIn/RdWriteDataIn  writeback info for non-memory ops
//   MemReq*             request channel (valid/ready, addr, write, wdata, wstrb)
//   MemResp*            load response channel
//   StallOut            holds PC, IF/ID, ID/EX, EX/MEM
//   RdWriteDataOut/RdAddrOut/RdWriteEnableOut  writeback triple to MEM/WB
//   MemFault            one-cycle pulse on a misaligned or illegal access
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [6:0]            OpCodeIn,
    input  logic [2:0]            Funct3In,
    input  logic [ADDR_WIDTH-1:0] AddrIn,
    input  logic [DATA_WIDTH-1:0] StoreDataIn,
    input  logic [4:0]            RdAddrIn,
    input  logic                  RdWriteEnableIn,
    input  logic [DATA_WIDTH-1:0] RdWriteDataIn,
    output logic                  MemReqValid,
    input  logic                  MemReqReady,
    output logic [ADDR_WIDTH-1:0] MemReqAddr,
    output logic                  MemReqWrite,
    output logic [DATA_WIDTH-1:0] MemReqWdata,
    output logic [7:0]            MemReqWstrb,
    input  logic                  MemRespValid,
    input  logic [DATA_WIDTH-1:0] MemRespRdata,
    output logic                  StallOut,
    output logic [DATA_WIDTH-1:0] RdWriteDataOut,
    output logic [4:0]            RdAddrOut,
    output logic                  RdWriteEnableOut,
    output logic                  MemFault
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [2:0]              r_funct3;
    logic [4:0]              r_rd;
    logic                    r_we;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [7:0]              r_wstrb;
    logic                    r_req_valid;
    logic [DATA_WIDTH-1:0]   r_load_data;

    logic                    w_is_load;
    logic                    w_is_store;
    logic                    w_is_mem;
    logic                    w_misaligned;
    logic                    w_bad_funct;
    logic                    w_legal;
    logic                    w_start;
    logic [7:0]              w_wstrb;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_load_ext;

    assign w_is_load   = (OpCodeIn == OP_LOAD);
    assign w_is_store  = (OpCodeIn == OP_STORE);
    assign w_is_mem    = w_is_load | w_is_store;
    assign w_bad_funct = (w_is_load && Funct3In == 3'b111) || (w_is_store && Funct3In[2]);
    assign w_legal     = !w_misaligned && !w_bad_funct;
    assign w_start     = (r_state == IDLE) && w_is_mem && w_legal;

    // funct3[1:0] encodes access size for both loads and stores
    always_comb begin
        w_misaligned = 1'b0;
        w_wstrb      = '0;
        w_wdata      = StoreDataIn;
        case (Funct3In[1:0])
            2'b00: begin
                w_wstrb = 8'h01 << AddrIn[2:0];
                w_wdata = {8{StoreDataIn[7:0]}};
            end
            2'b01: begin
                w_misaligned = AddrIn[0];
                w_wstrb      = 8'h03 << AddrIn[2:0];
                w_wdata      = {4{StoreDataIn[15:0]}};
            end
            2'b10: begin
                w_misaligned = |AddrIn[1:0];
                w_wstrb      = 8'h0F << AddrIn[2:0];
                w_wdata      = {2{StoreDataIn[31:0]}};
            end
            default: begin
                w_misaligned = |AddrIn[2:0];
                w_wstrb      = 8'hFF;
                w_wdata      = StoreDataIn;
            end
        endcase
        if (!w_is_store) begin
            w_wstrb = '0;
        end
    end

    // Bring the addressed lane down to bit 0, then extend by load type
    assign w_shifted = MemRespRdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_ext = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_ext = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_ext = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_load_ext = {56'b0, w_shifted[7:0]};
            3'b101:  w_load_ext = {48'b0, w_shifted[15:0]};
            3'b110:  w_load_ext = {32'b0, w_shifted[31:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_addr      <= '0;
            r_funct3    <= '0;
            r_rd        <= '0;
            r_we        <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_req_valid <= 1'b0;
            r_load_data <= '0;
        end else begin
            if (w_start) begin
                r_addr      <= AddrIn;
                r_funct3    <= Funct3In;
                r_rd        <= RdAddrIn;
                r_we        <= RdWriteEnableIn;
                r_write     <= w_is_store;
                r_wdata     <= w_wdata;
                r_wstrb     <= w_wstrb;
                r_req_valid <= 1'b1;
            end else if (r_state == REQ && MemReqReady) begin
                r_req_valid <= 1'b0;
            end
            if (r_state == WAIT && MemRespValid) begin
                r_load_data <= w_load_ext;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        StallOut         = 1'b0;
        RdWriteDataOut   = RdWriteDataIn;
        RdAddrOut        = RdAddrIn;
        RdWriteEnableOut = 1'b0;
        MemFault         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_mem) begin
                    if (w_legal) begin
                        StallOut = 1'b1;
                        w_next   = REQ;
                    end else begin
                        MemFault = 1'b1;
                    end
                end else begin
                    RdWriteEnableOut = RdWriteEnableIn;
                end
            end
            REQ: begin
                StallOut = 1'b1;
                if (MemReqReady) begin
                    w_next = r_write ? DONE : WAIT;
                end
            end
            WAIT: begin
                StallOut = 1'b1;
                if (MemRespValid) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
                if (!r_write) begin
                    RdWriteDataOut   = r_load_data;
                    RdAddrOut        = r_rd;
                    RdWriteEnableOut = r_we;
                end
            end
            default: w_next = IDLE;
        endcase
        if (!Rst) begin
            StallOut         = 1'b0;
            RdWriteEnableOut = 1'b0;
            MemFault         = 1'b0;
        end
    end

    assign MemReqValid = r_req_valid;
    assign MemReqAddr  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
    assign MemReqWrite = r_write;
    assign MemReqWdata = r_wdata;
    assign MemReqWstrb = r_wstrb;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl. Stimulus pushes expected requests
//   and expected retire results into queues; a monitor on the falling edge
//   compares them against what the DUT presents. A small bus model answers
//   requests with configurable ready/response latency.
module tb_mem_access_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [6:0]  OpCodeIn;
    logic [2:0]  Funct3In;
    logic [63:0] AddrIn;
    logic [63:0] StoreDataIn;
    logic [4:0]  RdAddrIn;
    logic        RdWriteEnableIn;
    logic [63:0] RdWriteDataIn;
    logic        MemReqValid;
    logic        MemReqReady;
    logic [63:0] MemReqAddr;
    logic        MemReqWrite;
    logic [63:0] MemReqWdata;
    logic [7:0]  MemReqWstrb;
    logic        MemRespValid;
    logic [63:0] MemRespRdata;
    logic        StallOut;
    logic [63:0] RdWriteDataOut;
    logic [4:0]  RdAddrOut;
    logic        RdWriteEnableOut;
    logic        MemFault;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .Clk(Clk), .Rst(Rst),
        .OpCodeIn(OpCodeIn), .Funct3In(Funct3In), .AddrIn(AddrIn),
        .StoreDataIn(StoreDataIn), .RdAddrIn(RdAddrIn),
        .RdWriteEnableIn(RdWriteEnableIn), .RdWriteDataIn(RdWriteDataIn),
        .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
        .MemReqAddr(MemReqAddr), .MemReqWrite(MemReqWrite),
        .MemReqWdata(MemReqWdata), .MemReqWstrb(MemReqWstrb),
        .MemRespValid(MemRespValid), .MemRespRdata(MemRespRdata),
        .StallOut(StallOut), .RdWriteDataOut(RdWriteDataOut),
        .RdAddrOut(RdAddrOut), .RdWriteEnableOut(RdWriteEnableOut),
        .MemFault(MemFault)
    );

    typedef struct {
        logic [63:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    typedef struct {
        logic        we;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        fault;
        int          stall;
    } ret_t;

    req_t        req_q[$];
    ret_t        ret_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        tb_active = 1'b0;
    int          rdy_delay = 0;
    int          rsp_delay = 0;
    logic [63:0] bus_rdata = '0;
    logic        stray = 1'b0;
    int          stall_cnt = 0;
    logic        was_rst = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Bus model: ready after rdy_delay cycles of valid, response rsp_delay
    // cycles after the load handshake; stray drives a response while idle.
    initial begin : bus
        logic hs_load;
        int   rcnt;
        int   pcnt;
        logic armed;
        rcnt = 0; pcnt = 0; armed = 1'b0;
        MemReqReady = 1'b0; MemRespValid = 1'b0; MemRespRdata = '0;
        forever begin
            @(negedge Clk);
            hs_load = MemReqValid && MemReqReady && !MemReqWrite;
            @(posedge Clk);
            #2;
            if (MemReqValid) begin
                MemReqReady = (rcnt >= rdy_delay);
                rcnt++;
            end else begin
                MemReqReady = 1'b0;
                rcnt = 0;
            end
            if (hs_load) begin
                armed = 1'b1;
                pcnt  = rsp_delay;
            end
            if (armed) begin
                if (pcnt == 0) begin
                    MemRespValid = 1'b1;
                    MemRespRdata = bus_rdata;
                    armed = 1'b0;
                end else begin
                    MemRespValid = 1'b0;
                    pcnt--;
                end
            end else begin
                MemRespValid = stray;
                MemRespRdata = stray ? 64'hDEAD_0000_DEAD_0000 : 64'h0;
            end
        end
    end

    always @(negedge Clk) begin : monitor
        req_t r;
        ret_t e;
        if (!Rst) begin
            chk("rst_stall", {63'b0, StallOut}, 64'd0);
            chk("rst_we", {63'b0, RdWriteEnableOut}, 64'd0);
            chk("rst_fault", {63'b0, MemFault}, 64'd0);
            was_rst   = 1'b1;
            stall_cnt = 0;
        end else begin
            if (was_rst) begin
                chk("post_rst_valid", {63'b0, MemReqValid}, 64'd0);
                chk("post_rst_write", {63'b0, MemReqWrite}, 64'd0);
                chk("post_rst_wstrb", {56'b0, MemReqWstrb}, 64'd0);
                chk("post_rst_addr", MemReqAddr, 64'd0);
                chk("post_rst_wdata", MemReqWdata, 64'd0);
                was_rst = 1'b0;
            end
            if (MemReqValid) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", {63'b0, MemReqValid}, 64'd0);
                end else begin
                    r = req_q[0];
                    chk("req_addr", MemReqAddr, r.addr);
                    chk("req_write", {63'b0, MemReqWrite}, {63'b0, r.write});
                    chk("req_wstrb", {56'b0, MemReqWstrb}, {56'b0, r.wstrb});
                    if (r.write) chk("req_wdata", MemReqWdata, r.wdata);
                    if (MemReqReady) req_q.delete(0);
                end
            end
            if (tb_active) begin
                if (StallOut) begin
                    stall_cnt++;
                end else begin
                    if (ret_q.size() == 0) begin
                        chk("unexpected_retire", 64'd1, 64'd0);
                    end else begin
                        e = ret_q.pop_front();
                        chk("wb_we", {63'b0, RdWriteEnableOut}, {63'b0, e.we});
                        chk("fault", {63'b0, MemFault}, {63'b0, e.fault});
                        if (e.we) begin
                            chk("wb_data", RdWriteDataOut, e.data);
                            chk("wb_rd", {59'b0, RdAddrOut}, {59'b0, e.rd});
                        end
                        chk("stall_cycles", 64'(stall_cnt), 64'(e.stall));
                    end
                    stall_cnt = 0;
                end
            end else begin
                chk("idle_we", {63'b0, RdWriteEnableOut}, 64'd0);
                chk("idle_fault", {63'b0, MemFault}, 64'd0);
            end
        end
    end

    task automatic drive_nop();
        OpCodeIn = 7'd0; Funct3In = 3'd0; AddrIn = '0; StoreDataIn = '0;
        RdAddrIn = 5'd0; RdWriteEnableIn = 1'b0; RdWriteDataIn = '0;
    endtask

    task automatic wait_retire();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (!StallOut) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("retire_timeout", 64'd0, 64'd1);
        @(posedge Clk);
        #1;
        tb_active = 1'b0;
        drive_nop();
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [4:0] rd, input logic we,
                         input logic [63:0] alu, input int rdy_d, input int rsp_d,
                         input logic [63:0] rdata, input logic has_req, input req_t ereq,
                         input ret_t eret);
        if (has_req) req_q.push_back(ereq);
        ret_q.push_back(eret);
        rdy_delay = rdy_d; rsp_delay = rsp_d; bus_rdata = rdata;
        OpCodeIn = op; Funct3In = f3; AddrIn = addr; StoreDataIn = sdata;
        RdAddrIn = rd; RdWriteEnableIn = we; RdWriteDataIn = alu;
        tb_active = 1'b1;
        wait_retire();
    endtask

    task automatic do_alu(input logic [63:0] data, input logic [4:0] rd);
        issue(OP_ALU, 3'd0, 64'h0, 64'h0, rd, 1'b1, data, 0, 0, 64'h0, 1'b0,
              '{64'h0, 1'b0, 64'h0, 8'h0}, '{1'b1, data, rd, 1'b0, 0});
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [63:0] addr, input logic [4:0] rd,
                           input logic [63:0] rdata, input int rdy_d, input int rsp_d,
                           input logic [63:0] exp_data, input logic [63:0] exp_addr, input int stall);
        issue(OP_LOAD, f3, addr, 64'h0, rd, 1'b1, 64'h5555, rdy_d, rsp_d, rdata, 1'b1,
              '{exp_addr, 1'b0, 64'h0, 8'h00}, '{1'b1, exp_data, rd, 1'b0, stall});
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] sdata,
                            input int rdy_d, input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                            input logic [63:0] exp_wdata, input int stall);
        issue(OP_STORE, f3, addr, sdata, 5'd9, 1'b1, 64'h7777, rdy_d, 0, 64'h0, 1'b1,
              '{exp_addr, 1'b1, exp_wdata, exp_strb}, '{1'b0, 64'h0, 5'd0, 1'b0, stall});
    endtask

    task automatic do_fault(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr);
        issue(op, f3, addr, 64'h1234, 5'd4, 1'b1, 64'h9999, 0, 0, 64'h0, 1'b0,
              '{64'h0, 1'b0, 64'h0, 8'h0}, '{1'b0, 64'h0, 5'd0, 1'b1, 0});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : stim
        Rst = 1'b0;
        drive_nop();
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;

        do_alu(64'h1234, 5'd5);
        do_load(3'b000, 64'h1003, 5'd7, 64'h0000_0000_8000_0000, 0, 0,
                64'hFFFF_FFFF_FFFF_FF80, 64'h1000, 3);
        do_store(3'b001, 64'h2006, 64'h0000_0000_0000_ABCD, 2, 64'h2000, 8'hC0,
                 64'hABCD_ABCD_ABCD_ABCD, 4);
        do_fault(OP_LOAD, 3'b010, 64'h3002);
        do_load(3'b110, 64'h4004, 5'd10, 64'hFFFF_FFFF_0000_0001, 0, 3,
                64'h0000_0000_FFFF_FFFF, 64'h4000, 6);
        stray = 1'b1;
        do_alu(64'hDEAD_BEEF, 5'd3);
        stray = 1'b0;
        do_fault(OP_STORE, 3'b100, 64'h10);
        do_fault(OP_LOAD, 3'b111, 64'h0);
        do_fault(OP_STORE, 3'b011, 64'h0C);

        // Back-to-back memory ops with no idle cycle between them
        do_store(3'b000, 64'h6005, 64'hFFFF_FFFF_FFFF_FF5A, 0, 64'h6000, 8'h20,
                 64'h5A5A_5A5A_5A5A_5A5A, 2);
        do_load(3'b011, 64'h7008, 5'd12, 64'h0123_4567_89AB_CDEF, 0, 0,
                64'h0123_4567_89AB_CDEF, 64'h7008, 3);

        // Reset while the load waits for its response; response arrives late
        req_q.push_back('{64'h5000, 1'b0, 64'h0, 8'h00});
        rdy_delay = 0; rsp_delay = 3; bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        OpCodeIn = OP_LOAD; Funct3In = 3'b011; AddrIn = 64'h5000; RdAddrIn = 5'd20;
        RdWriteEnableIn = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        drive_nop();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        repeat (6) @(posedge Clk);
        #1;

        do_load(3'b001, 64'h8006, 5'd13, 64'h8001_0000_0000_0000, 1, 1,
                64'hFFFF_FFFF_FFFF_8001, 64'h8000, 5);
        do_load(3'b101, 64'h8006, 5'd14, 64'h8001_0000_0000_0000, 0, 0,
                64'h0000_0000_0000_8001, 64'h8000, 3);
        do_store(3'b010, 64'h9004, 64'h0000_0000_CAFE_F00D, 1, 64'h9000, 8'hF0,
                 64'hCAFE_F00D_CAFE_F00D, 3);
        do_store(3'b011, 64'hA008, 64'h1122_3344_5566_7788, 0, 64'hA008, 8'hFF,
                 64'h1122_3344_5566_7788, 2);
        do_load(3'b100, 64'hB001, 5'd15, 64'h0000_0000_0000_F200, 0, 0,
                64'h0000_0000_0000_00F2, 64'hB000, 3);
        do_alu(64'h0BAD_F00D, 5'd31);

        repeat (4) @(posedge Clk);
        #1;
        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("ret_q_drained", 64'(ret_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
